// File: rtl/if_stage_if.sv
// if_stage_if: instruction-memory request/response bus between the fetch stage and memory.
interface if_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/if_stage.sv
// if_stage: instruction fetch with stall skid buffer and branch redirect flushing.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NO_OP    = 32'hF000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_hazard,
    input  logic              PC_hazard,
    input  logic [31:0]       branch_target,
    if_stage_if.master        imem,
    output logic [31:0]       instruction_out,
    output logic [31:0]       PC_out,
    output logic              inst_valid
);
    typedef enum logic [1:0] {RESET, FETCH, STALL, FLUSH} state_t;
    state_t      state, n_state;
    logic [31:0] fetch_pc, n_fetch, addr, n_addr, n_ins, n_pc, skid, n_skid, skid_pc, n_skid_pc;
    logic        n_valid;
    assign imem.imem_req  = (state == FETCH) || (state == FLUSH);
    assign imem.imem_addr = addr;
    always_comb begin
        n_state   = state;
        n_fetch   = fetch_pc;
        n_addr    = addr;
        n_ins     = instruction_out;
        n_pc      = PC_out;
        n_valid   = inst_valid;
        n_skid    = skid;
        n_skid_pc = skid_pc;
        case (state)
            RESET: begin
                n_state = FETCH;
                n_addr  = fetch_pc;
            end
            FETCH: begin
                if (PC_hazard) begin
                    n_ins   = NO_OP;
                    n_valid = 1'b0;
                    n_fetch = branch_target;
                    if (imem.imem_ready) n_addr = branch_target;
                    else n_state = FLUSH;
                end else if (data_hazard) begin
                    // IF/ID is frozen, so park the returned word until it can take it
                    if (imem.imem_ready) begin
                        n_skid    = imem.imem_rdata;
                        n_skid_pc = addr;
                        n_fetch   = addr + 32'd1;
                        n_state   = STALL;
                    end
                end else if (imem.imem_ready) begin
                    n_ins   = imem.imem_rdata;
                    n_pc    = addr;
                    n_valid = 1'b1;
                    n_fetch = addr + 32'd1;
                    n_addr  = addr + 32'd1;
                end else begin
                    n_ins   = NO_OP;
                    n_valid = 1'b0;
                end
            end
            STALL: begin
                if (PC_hazard) begin
                    n_ins   = NO_OP;
                    n_valid = 1'b0;
                    n_fetch = branch_target;
                    n_addr  = branch_target;
                    n_state = FETCH;
                end else if (!data_hazard) begin
                    n_ins   = skid;
                    n_pc    = skid_pc;
                    n_valid = 1'b1;
                    n_addr  = fetch_pc;
                    n_state = FETCH;
                end
            end
            FLUSH: begin
                // stale request must still complete; its data is dropped
                n_ins   = NO_OP;
                n_valid = 1'b0;
                n_fetch = PC_hazard ? branch_target : fetch_pc;
                if (imem.imem_ready) begin
                    n_addr  = n_fetch;
                    n_state = FETCH;
                end
            end
            default: n_state = RESET;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= RESET;
            fetch_pc        <= RESET_PC;
            addr            <= RESET_PC;
            instruction_out <= NO_OP;
            PC_out          <= 32'd0;
            inst_valid      <= 1'b0;
            skid            <= 32'd0;
            skid_pc         <= 32'd0;
        end else begin
            state           <= n_state;
            fetch_pc        <= n_fetch;
            addr            <= n_addr;
            instruction_out <= n_ins;
            PC_out          <= n_pc;
            inst_valid      <= n_valid;
            skid            <= n_skid;
            skid_pc         <= n_skid_pc;
        end
    end
endmodule
